alu_arbiter: RTL and testbench

Shares one combinational ALU (32-bit operands, 6-bit opcode, result plus carry/zero/negative/overflow flags) between two requesters. The block accepts one operation at a time over valid/ready handshakes, drives the ALU from registered operands for one execute cycle, and returns a registered result and flags with the requester's ID. It sits between the issue logic and the shared ALU instance.

---
 rtl/alu_arbiter.sv | 119 +++++++++++
 tb/tb_alu_arbiter.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between two requesters using an IDLE/EXEC/RESP sequence.
// Define ALU_ARB_RR_EN to break ties round-robin; the default build gives req0 fixed priority on ties.
module alu_arbiter #(
    parameter int WIDTH = 32,
    parameter int OPW   = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [OPW-1:0]   req0_opcode,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [OPW-1:0]   req1_opcode,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [OPW-1:0]   alu_opcode,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_carry,
    input  logic             alu_zero,
    input  logic             alu_negative,
    input  logic             alu_overflow,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_result,
    output logic [3:0]       rsp_flags,
    output logic             busy
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    localparam logic [OPW-1:0] OP_ADD  = OPW'(1);
    localparam logic [OPW-1:0] OP_SUB  = OPW'(2);
    localparam logic [OPW-1:0] OP_ADDI = OPW'(5);

    logic [1:0] state;
    logic       tie_to_req1;
    logic       grant0;
    logic       grant1;
    logic       arith_op;

`ifdef ALU_ARB_RR_EN
    // Set when req1 should win the next tie, i.e. req0 was granted last.
    logic rr_req1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            rr_req1 <= 1'b0;
        else if (grant0)
            rr_req1 <= 1'b1;
        else if (grant1)
            rr_req1 <= 1'b0;
    end

    assign tie_to_req1 = rr_req1;
`else
    assign tie_to_req1 = 1'b0;
`endif

    assign grant0 = (state == IDLE) && req0_valid && !(req1_valid && tie_to_req1);
    assign grant1 = (state == IDLE) && req1_valid && !grant0;

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign rsp_valid  = (state == RESP);
    assign busy       = (state != IDLE);

    // Carry/overflow are meaningful only for arithmetic opcodes.
    assign arith_op = (alu_opcode == OP_ADD) || (alu_opcode == OP_SUB) || (alu_opcode == OP_ADDI);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_opcode <= '0;
            rsp_id     <= 1'b0;
            rsp_result <= '0;
            rsp_flags  <= 4'b0000;
        end else begin
            case (state)
                IDLE: begin
                    if (grant0) begin
                        alu_a      <= req0_a;
                        alu_b      <= req0_b;
                        alu_opcode <= req0_opcode;
                        rsp_id     <= 1'b0;
                        state      <= EXEC;
                    end else if (grant1) begin
                        alu_a      <= req1_a;
                        alu_b      <= req1_b;
                        alu_opcode <= req1_opcode;
                        rsp_id     <= 1'b1;
                        state      <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_result <= alu_result;
                    rsp_flags  <= {alu_carry & arith_op, alu_zero, alu_negative,
                                   alu_overflow & arith_op};
                    state      <= RESP;
                end
                RESP: begin
                    if (rsp_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter with a behavioural ALU model attached.
// The logic-op branch of the model drives carry/overflow high so flag masking is visible.
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [5:0]  req0_opcode, req1_opcode;
    logic [31:0] alu_a, alu_b;
    logic [5:0]  alu_opcode;
    logic [31:0] alu_result;
    logic        alu_carry, alu_zero, alu_negative, alu_overflow;
    logic        rsp_valid, rsp_ready, rsp_id, busy;
    logic [31:0] rsp_result;
    logic [3:0]  rsp_flags;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.WIDTH(32), .OPW(6)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_opcode(req0_opcode),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_opcode(req1_opcode),
        .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
        .alu_result(alu_result), .alu_carry(alu_carry), .alu_zero(alu_zero),
        .alu_negative(alu_negative), .alu_overflow(alu_overflow),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_flags(rsp_flags), .busy(busy)
    );

    logic [32:0] sum, diff;
    always_comb begin
        sum          = {1'b0, alu_a} + {1'b0, alu_b};
        diff         = {1'b0, alu_a} - {1'b0, alu_b};
        alu_result   = '0;
        alu_carry    = 1'b1;
        alu_overflow = 1'b1;
        case (alu_opcode)
            6'd0: alu_result = alu_a & alu_b;
            6'd1, 6'd5: begin
                alu_result   = sum[31:0];
                alu_carry    = sum[32];
                alu_overflow = (alu_a[31] == alu_b[31]) && (sum[31] != alu_a[31]);
            end
            6'd2: begin
                alu_result   = diff[31:0];
                alu_carry    = diff[32];
                alu_overflow = (alu_a[31] != alu_b[31]) && (diff[31] != alu_a[31]);
            end
            6'd3: alu_result = alu_a | alu_b;
            6'd4: alu_result = alu_a ^ alu_b;
            default: alu_result = '0;
        endcase
        alu_zero     = (alu_result == 32'd0);
        alu_negative = alu_result[31];
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic id, input logic [31:0] a, input logic [31:0] b,
                         input logic [5:0] op);
        if (id == 1'b0) begin
            req0_valid = 1'b1; req0_a = a; req0_b = b; req0_opcode = op;
        end else begin
            req1_valid = 1'b1; req1_a = a; req1_b = b; req1_opcode = op;
        end
    endtask

    // Entered just after a rising edge with the DUT in IDLE; leaves it likewise.
    task automatic do_op(input logic id, input logic [31:0] a, input logic [31:0] b,
                         input logic [5:0] op, input logic [31:0] er, input logic [3:0] ef,
                         input int stall);
        drive(id, a, b, op);
        rsp_ready = 1'b0;
        @(negedge clk);
        chk("grant", {req1_ready, req0_ready}, id ? 2'b10 : 2'b01);
        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge clk);
        chk("exec_busy", busy, 1'b1);
        chk("exec_rsp_valid", rsp_valid, 1'b0);
        chk("exec_ready", {req1_ready, req0_ready}, 2'b00);
        chk("alu_operands", {alu_a, alu_b}, {a, b});
        chk("alu_opcode", alu_opcode, op);
        @(posedge clk); #1;
        for (int i = 0; i < stall; i++) begin
            req0_valid = 1'b1; req1_valid = 1'b1;
            @(negedge clk);
            chk("stall_rsp_valid", rsp_valid, 1'b1);
            chk("stall_result", rsp_result, er);
            chk("stall_flags", rsp_flags, ef);
            chk("stall_ready", {req1_ready, req0_ready}, 2'b00);
            chk("stall_alu_a", alu_a, a);
            @(posedge clk); #1;
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        rsp_ready  = 1'b1;
        @(negedge clk);
        chk("rsp_valid", rsp_valid, 1'b1);
        chk("rsp_id", rsp_id, id);
        chk("rsp_result", rsp_result, er);
        chk("rsp_flags", rsp_flags, ef);
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        @(negedge clk);
        chk("rsp_drop", rsp_valid, 1'b0);
        chk("idle_busy", busy, 1'b0);
        @(posedge clk); #1;
    endtask

    initial begin
        reset = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
        req0_a = '0; req0_b = '0; req0_opcode = '0;
        req1_a = '0; req1_b = '0; req1_opcode = '0;
        #2;
        chk("rst_outputs", {req0_ready, req1_ready, rsp_valid, rsp_id, busy}, 5'b0);
        chk("rst_alu", {alu_a, alu_b, 26'b0, alu_opcode}, 96'b0);
        chk("rst_rsp", {rsp_result, rsp_flags}, 36'b0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;

        do_op(1'b0, 32'h7FFF_FFFF, 32'd1, 6'd1, 32'h8000_0000, 4'b0011, 0);
        do_op(1'b1, 32'd5, 32'd7, 6'd2, 32'hFFFF_FFFE, 4'b1010, 4);
        do_op(1'b0, 32'd1, 32'd1, 6'd1, 32'd2, 4'b0000, 0);
        do_op(1'b0, 32'd0, 32'd0, 6'd3, 32'd0, 4'b0100, 0);
        do_op(1'b1, 32'd3, 32'd4, 6'd9, 32'd0, 4'b0100, 0);

        // Reset while in EXEC: everything clears at once and no response appears.
        drive(1'b1, 32'd8, 32'd9, 6'd1);
        @(posedge clk); #1;
        req1_valid = 1'b0;
        @(negedge clk);
        chk("pre_reset_busy", busy, 1'b1);
        reset = 1'b1;
        #1;
        chk("async_rst_state", {busy, rsp_valid, rsp_id}, 3'b000);
        chk("async_rst_alu", {alu_a, alu_opcode}, 38'b0);
        chk("async_rst_rsp", {rsp_result, rsp_flags}, 36'b0);
        @(negedge clk);
        reset = 1'b0;
        rsp_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("no_rsp_after_rst", {rsp_valid, busy}, 2'b00);
        end
        rsp_ready = 1'b0;
        @(posedge clk); #1;
        do_op(1'b0, 32'd2, 32'd3, 6'd5, 32'd5, 4'b0000, 0);

        // Fresh reset so the tie pointer starts at req0.
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        drive(1'b0, 32'd10, 32'd1, 6'd1);
        drive(1'b1, 32'd3, 32'd5, 6'd3);
        rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
`ifdef ALU_ARB_RR_EN
            logic exp_id = (i % 2 == 1);
`else
            logic exp_id = 1'b0;
`endif
            @(negedge clk);
            chk("tie_grant", {req1_ready, req0_ready}, exp_id ? 2'b10 : 2'b01);
            @(negedge clk);
            @(negedge clk);
            chk("tie_rsp_id", {rsp_valid, rsp_id}, {1'b1, exp_id});
            chk("tie_result", rsp_result, exp_id ? 32'd7 : 32'd11);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge clk);
        chk("final_idle", busy, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
